// File: rtl/input_axis_ramp.sv
// input_axis_ramp: multi-channel control-axis generator.
// Each channel either ramps a value from up/down levels on a shared tick
// (with hold-based acceleration and optional spring-return), passes a signed
// stick through with clamping, or freezes. Deadzone thresholds on the stick
// are provided as registered digital outputs in every mode.

module input_axis_ramp_lane #(
  parameter int WIDTH       = 8,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 254,
  parameter int CENTER      = 128,
  parameter int ACCEL_TICKS = 32,
  parameter int ACCEL_STEP  = 4,
  parameter int DEADZONE    = 64
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tick,
  input  logic             up,
  input  logic             down,
  input  logic [1:0]       mode,
  input  logic [7:0]       analog_in,
  output logic [WIDTH-1:0] value,
  output logic             dig_lo,
  output logic             dig_hi
);
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [WIDTH:0]   MIN_W = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] CEN_V = WIDTH'(CENTER);
  localparam logic [WIDTH:0]   FAST  = (WIDTH+1)'(ACCEL_STEP);
  localparam logic [HW-1:0]    AT    = HW'(ACCEL_TICKS);
  localparam logic signed [8:0] DZ   = 9'(DEADZONE);

  logic [WIDTH-1:0] value_q, value_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [1:0]       pdir_q, pdir_d;   // direction seen on the previous tick
  logic             lo_q, lo_d, hi_q, hi_d;

  logic [1:0]       dir;              // {down, up}, both pressed -> 00
  logic [WIDTH:0]   step, sum;
  logic [WIDTH-1:0] inc_v, dec_v, spr_v, pass_v, scaled;
  logic [7:0]       u;
  logic signed [8:0] s9;

  // Next-state for value, hold counter and thresholds
  always_comb begin
    dir    = {down & ~up, up & ~down};
    step   = (hold_q == AT) ? FAST : (WIDTH+1)'(1);
    sum    = {1'b0, value_q} + step;
    inc_v  = (sum > MAX_W) ? MAX_V : sum[WIDTH-1:0];
    dec_v  = ({1'b0, value_q} < MIN_W + step) ? MIN_V : value_q - step[WIDTH-1:0];
    spr_v  = value_q;
    if (value_q < CEN_V) spr_v = value_q + 1'b1;
    else if (value_q > CEN_V) spr_v = value_q - 1'b1;
    // 127 - s taken modulo 256 lands exactly on 0..255 for any signed s
    u      = 8'd127 - analog_in;
    scaled = WIDTH'(u) << (WIDTH - 8);
    pass_v = scaled;
    if (scaled > MAX_V) pass_v = MAX_V;
    else if (scaled < MIN_V) pass_v = MIN_V;
    s9     = {analog_in[7], analog_in};
    lo_d   = (s9 < -DZ);
    hi_d   = (s9 > DZ);

    value_d = value_q;
    hold_d  = hold_q;
    pdir_d  = pdir_q;
    case (mode)
      2'b00: begin
        value_d = pass_v;
        hold_d  = '0;
        pdir_d  = 2'b00;
      end
      2'b11: begin
        hold_d  = '0;
        pdir_d  = 2'b00;
      end
      default: begin
        if (tick) begin
          pdir_d = dir;
          if (dir == 2'b00)        hold_d = '0;
          else if (dir == pdir_q)  hold_d = (hold_q == AT) ? AT : hold_q + 1'b1;
          else                     hold_d = HW'(1);
          if (dir == 2'b01)        value_d = inc_v;
          else if (dir == 2'b10)   value_d = dec_v;
          else if (mode == 2'b10)  value_d = spr_v;
        end
      end
    endcase
  end

  // Lane state registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      value_q <= MIN_V;
      hold_q  <= '0;
      pdir_q  <= 2'b00;
      lo_q    <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      value_q <= value_d;
      hold_q  <= hold_d;
      pdir_q  <= pdir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign value  = value_q;
  assign dig_lo = lo_q;
  assign dig_hi = hi_q;
endmodule

module input_axis_ramp #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int TICK_DIV    = 196850,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 254,
  parameter int CENTER      = 128,
  parameter int ACCEL_TICKS = 32,
  parameter int ACCEL_STEP  = 4,
  parameter int DEADZONE    = 64
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       down,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [8*CHANNELS-1:0]     analog_in,
  output logic [WIDTH*CHANNELS-1:0] value,
  output logic [CHANNELS-1:0]       dig_lo,
  output logic [CHANNELS-1:0]       dig_hi,
  output logic                      tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Shared prescaler: 0..TICK_DIV-1, strobe on the last count
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    input_axis_ramp_lane #(
      .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .CENTER(CENTER),
      .ACCEL_TICKS(ACCEL_TICKS), .ACCEL_STEP(ACCEL_STEP), .DEADZONE(DEADZONE)
    ) u_lane (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .tick     (tick),
      .up       (up[g]),
      .down     (down[g]),
      .mode     (mode[2*g +: 2]),
      .analog_in(analog_in[8*g +: 8]),
      .value    (value[WIDTH*g +: WIDTH]),
      .dig_lo   (dig_lo[g]),
      .dig_hi   (dig_hi[g])
    );
  end
endmodule

// File: tb/tb_input_axis_ramp.sv
// Directed bench for input_axis_ramp: two 8-bit channels at TICK_DIV=4 plus
// a single 10-bit channel for the scaled passthrough.
`timescale 1ns/1ps
module tb_input_axis_ramp;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  up, down, dig_lo, dig_hi;
  logic [3:0]  mode;
  logic [15:0] analog_in;
  logic [15:0] value;
  logic        tick;
  logic [7:0]  an10;
  logic [1:0]  mode10;
  logic [9:0]  value10;
  logic        lo10, hi10, tick10;
  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  input_axis_ramp #(.CHANNELS(2), .WIDTH(8), .TICK_DIV(4), .MIN_VAL(0), .MAX_VAL(254),
    .CENTER(128), .ACCEL_TICKS(32), .ACCEL_STEP(4), .DEADZONE(64)) dut (
    .clk_sys(clk), .reset(reset), .up(up), .down(down), .mode(mode),
    .analog_in(analog_in), .value(value), .dig_lo(dig_lo), .dig_hi(dig_hi), .tick(tick));

  input_axis_ramp #(.CHANNELS(1), .WIDTH(10), .TICK_DIV(4), .MIN_VAL(0), .MAX_VAL(1023),
    .CENTER(512), .ACCEL_TICKS(32), .ACCEL_STEP(4), .DEADZONE(64)) dut10 (
    .clk_sys(clk), .reset(reset), .up(1'b0), .down(1'b0), .mode(mode10),
    .analog_in(an10), .value(value10), .dig_lo(lo10), .dig_hi(hi10), .tick(tick10));

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Advance through the next tick cycle; returns just after the updating edge
  task automatic wait_tick();
    int k = 0;
    while (tick !== 1'b1 && k < 20) begin cyc(); k++; end
    check("tick_timeout", int'(k < 20), 1);
    cyc();
  endtask

  function automatic int v0(); return int'(value[7:0]);  endfunction
  function automatic int v1(); return int'(value[15:8]); endfunction

  initial begin
    reset = 1'b1; up = '0; down = '0; mode = 4'b0011; analog_in = '0;
    an10 = 8'h00; mode10 = 2'b00;
    #12;
    check("rst_value0", v0(), 0);
    check("rst_value1", v1(), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_dig", int'({dig_lo, dig_hi}), 0);
    check("rst_value10", int'(value10), 0);
    cyc();
    reset = 1'b0;

    // Passthrough on channel 1; channel 0 frozen
    analog_in[15:8] = 8'h80;
    check("pt_latency", v1(), 0);
    cyc(); check("pt_m128", v1(), 254);
    analog_in[15:8] = 8'h00;  cyc(); check("pt_zero", v1(), 127);
    analog_in[15:8] = 8'h7f;  cyc(); check("pt_p127", v1(), 0);
    check("frozen_ch0", v0(), 0);
    check("w10_zero", int'(value10), 508);
    an10 = 8'h80; cyc(); check("w10_m128", int'(value10), 1020);

    // Thresholds
    analog_in[15:8] = -8'sd65; cyc(); check("thr_m65", int'({dig_lo[1], dig_hi[1]}), 2);
    analog_in[15:8] = -8'sd64; cyc(); check("thr_m64", int'({dig_lo[1], dig_hi[1]}), 0);
    analog_in[15:8] = 8'sd65;  cyc(); check("thr_p65", int'({dig_lo[1], dig_hi[1]}), 1);
    check("thr_ch0", int'({dig_lo[0], dig_hi[0]}), 0);

    // Ramp-hold full range from reset
    reset = 1'b1; cyc(); reset = 1'b0;
    mode[1:0] = 2'b01; up[0] = 1'b1;
    for (int t = 1; t <= 95; t++) begin
      int e;
      wait_tick();
      e = (t <= 32) ? t : 32 + 4 * (t - 32);
      if (e > 254) e = 254;
      check($sformatf("ramp_up_t%0d", t), v0(), e);
    end
    up[0] = 1'b0; down[0] = 1'b1;
    // Hold is still saturated on the first reversed tick, so the step is 4
    wait_tick(); check("down_first", v0(), 250);
    repeat (120) wait_tick();
    check("down_floor", v0(), 0);
    repeat (3) wait_tick();
    check("down_nowrap", v0(), 0);
    down[0] = 1'b0;

    // Both pressed at 100 after acceleration: hold resets
    mode[1:0] = 2'b00; analog_in[7:0] = 8'd63; cyc(); check("set_64", v0(), 64);
    mode[1:0] = 2'b01; up[0] = 1'b1;
    repeat (33) wait_tick();
    check("accel_100", v0(), 100);
    down[0] = 1'b1;
    repeat (10) wait_tick();
    check("both_hold", v0(), 100);
    down[0] = 1'b0;
    wait_tick(); check("both_release", v0(), 101);
    up[0] = 1'b0;

    // Spring return
    mode[1:0] = 2'b00; analog_in[7:0] = -8'sd4; cyc(); check("set_131", v0(), 131);
    mode[1:0] = 2'b10;
    wait_tick(); check("spr_130", v0(), 130);
    wait_tick(); check("spr_129", v0(), 129);
    wait_tick(); check("spr_128", v0(), 128);
    wait_tick(); check("spr_stay", v0(), 128);
    mode[1:0] = 2'b00; analog_in[7:0] = 8'sd1; cyc(); check("set_126", v0(), 126);
    mode[1:0] = 2'b10;
    wait_tick(); check("spr_127", v0(), 127);
    wait_tick(); check("spr_128b", v0(), 128);

    // Asynchronous reset mid-ramp
    mode[1:0] = 2'b00; analog_in[7:0] = -8'sd73; cyc(); check("set_200", v0(), 200);
    mode[1:0] = 2'b01;
    #2 reset = 1'b1;
    #1 check("arst_value", v0(), 0);
    check("arst_tick", int'(tick), 0);
    #1 reset = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin cyc(); n++; end
    // Release cycle counts as cycle 1, so tick is seen after TICK_DIV-1 edges
    check("arst_first_tick", n, 3);
    check("arst_hold0", v0(), 0);

    // Mode switch 00 -> 01 keeps the passthrough value
    mode[1:0] = 2'b00; analog_in[7:0] = 8'h00; cyc(); check("sw_127", v0(), 127);
    mode[1:0] = 2'b01; up[0] = 1'b1;
    wait_tick(); check("sw_128", v0(), 128);
    up[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
